// File: rtl/vigna_bus_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vigna_bus_arbiter_if                                                 |
// | Instruction, data and shared memory bus bundle for the arbiter.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface vigna_bus_arbiter_if;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        bus_err;
    logic [31:0] err_addr;

    // The arbiter itself takes the slave view.
    modport slave (
        input  i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        output i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb,
        output bus_err, err_addr
    );

    modport master (
        output i_valid, i_addr, d_valid, d_addr, d_wdata, d_wstrb, m_ready, m_rdata,
        input  i_ready, i_rdata, d_ready, d_rdata, m_valid, m_addr, m_wdata, m_wstrb,
        input  bus_err, err_addr
    );
endinterface
`default_nettype wire

// File: rtl/vigna_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vigna_bus_arbiter                                                    |
// | Two-to-one i/d memory port arbiter with optional no-response timeout.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module vigna_bus_arbiter #(
    parameter bit          ROUND_ROBIN = 1'b1,
    parameter int unsigned TIMEOUT     = 0
) (
    input  wire logic          clk,
    input  wire logic          resetn,
    vigna_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    state_t      state_q,    state_d;
    logic        grant_q,    grant_d;     // 1 = d granted
    logic        last_q,     last_d;      // 1 = d granted last
    logic [15:0] cnt_q,      cnt_d;
    logic        m_valid_q,  m_valid_d;
    logic [31:0] m_addr_q,   m_addr_d;
    logic [31:0] m_wdata_q,  m_wdata_d;
    logic [3:0]  m_wstrb_q,  m_wstrb_d;
    logic        i_ready_q,  i_ready_d;
    logic        d_ready_q,  d_ready_d;
    logic [31:0] resp_q,     resp_d;
    logic        bus_err_q,  bus_err_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        pick_d;
    logic        timeout_fire;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        m_valid_d    = m_valid_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wstrb_d    = m_wstrb_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        resp_d       = resp_q;
        bus_err_d    = 1'b0;
        err_addr_d   = err_addr_q;
        // On a tie d wins unless round-robin says d went last.
        pick_d       = bus.d_valid && (!bus.i_valid || !ROUND_ROBIN || !last_q);
        timeout_fire = (TIMEOUT != 0) && (cnt_q == TO_LAST) && !bus.m_ready;

        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid || bus.d_valid) begin
                    grant_d   = pick_d;
                    m_addr_d  = pick_d ? bus.d_addr  : bus.i_addr;
                    m_wdata_d = pick_d ? bus.d_wdata : 32'd0;
                    m_wstrb_d = pick_d ? bus.d_wstrb : 4'd0;
                    m_valid_d = 1'b1;
                    cnt_d     = 16'd0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bus.m_ready || timeout_fire) begin
                    resp_d    = bus.m_ready ? bus.m_rdata : 32'd0;
                    m_valid_d = 1'b0;
                    last_d    = grant_q;
                    i_ready_d = !grant_q;
                    d_ready_d = grant_q;
                    state_d   = ST_RESP;
                    if (!bus.m_ready) begin
                        bus_err_d  = 1'b1;
                        err_addr_d = m_addr_q;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                m_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= 1'b0;
            last_q     <= 1'b0;
            cnt_q      <= 16'd0;
            m_valid_q  <= 1'b0;
            m_addr_q   <= 32'd0;
            m_wdata_q  <= 32'd0;
            m_wstrb_q  <= 4'd0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            resp_q     <= 32'd0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            m_valid_q  <= m_valid_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
            resp_q     <= resp_d;
            bus_err_q  <= bus_err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bus.m_valid  = m_valid_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;
    assign bus.m_wstrb  = m_wstrb_q;
    assign bus.i_ready  = i_ready_q;
    assign bus.d_ready  = d_ready_q;
    assign bus.i_rdata  = resp_q;
    assign bus.d_rdata  = resp_q;
    assign bus.bus_err  = bus_err_q;
    assign bus.err_addr = err_addr_q;
endmodule
`default_nettype wire

// File: tb/tb_vigna_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vigna_bus_arbiter                                                 |
// | Randomised self-checking bench: round-robin/timeout and fixed DUTs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_vigna_bus_arbiter;
    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_fail;

    vigna_bus_arbiter_if bus_a ();
    vigna_bus_arbiter_if bus_b ();

    vigna_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(4)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_a)
    );

    vigna_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_a.i_valid = 0; bus_a.i_addr = 0; bus_a.d_valid = 0; bus_a.d_addr = 0;
        bus_a.d_wdata = 0; bus_a.d_wstrb = 0; bus_a.m_ready = 0; bus_a.m_rdata = 0;
        bus_b.i_valid = 0; bus_b.i_addr = 0; bus_b.d_valid = 0; bus_b.d_addr = 0;
        bus_b.d_wdata = 0; bus_b.d_wstrb = 0; bus_b.m_ready = 0; bus_b.m_rdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb, bus_a.i_ready, bus_a.d_ready,
             bus_a.i_rdata, bus_a.d_rdata, bus_a.bus_err, bus_a.err_addr} !== '0) begin
            n_fail++; $display("FAIL reset_a: got nonzero outputs m_valid=%b m_addr=%h want all 0", bus_a.m_valid, bus_a.m_addr);
        end
        n_cmp++;
        if ({bus_b.m_valid, bus_b.i_ready, bus_b.d_ready, bus_b.bus_err} !== 4'b0) begin
            n_fail++; $display("FAIL reset_b: got %b want 0000", {bus_b.m_valid, bus_b.i_ready, bus_b.d_ready, bus_b.bus_err});
        end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        bus_a.i_valid = 1; bus_a.i_addr = 32'h100;
        tick();
        n_cmp++;
        if ({bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb} !== {1'b1, 32'h100, 32'h0, 4'h0}) begin
            n_fail++; $display("FAIL single_issue: got v=%b a=%h w=%h s=%h want 1/100/0/0",
                               bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb);
        end
        bus_a.m_ready = 1; bus_a.m_rdata = 32'hDEADBEEF;
        tick();
        bus_a.m_ready = 0;
        n_cmp++;
        if ({bus_a.i_ready, bus_a.d_ready, bus_a.m_valid, bus_a.i_rdata} !== {3'b100, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL single_resp: got ir=%b dr=%b mv=%b rd=%h want 1/0/0/deadbeef",
                               bus_a.i_ready, bus_a.d_ready, bus_a.m_valid, bus_a.i_rdata);
        end
        bus_a.i_valid = 0;
        tick();
        n_cmp++;
        if ({bus_a.i_ready, bus_a.d_ready, bus_a.m_valid} !== 3'b000) begin
            n_fail++; $display("FAIL single_done: got %b want 000", {bus_a.i_ready, bus_a.d_ready, bus_a.m_valid});
        end
    endtask

    task automatic test_store_wait();
        logic [31:0] r;
        do_reset();
        r = $urandom;
        bus_a.d_valid = 1; bus_a.d_addr = 32'h2000; bus_a.d_wdata = 32'h12345678; bus_a.d_wstrb = 4'b0011;
        tick();
        for (int c = 1; c <= 3; c++) begin
            n_cmp++;
            if ({bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb} !== {1'b1, 32'h2000, 32'h12345678, 4'b0011}) begin
                n_fail++; $display("FAIL store_stable c=%0d: got v=%b a=%h w=%h s=%h want 1/2000/12345678/3",
                                   c, bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb);
            end
            bus_a.d_addr = $urandom; bus_a.d_wdata = $urandom;
            bus_a.m_ready = (c == 3); bus_a.m_rdata = r;
            tick();
        end
        bus_a.m_ready = 0;
        n_cmp++;
        if ({bus_a.d_ready, bus_a.i_ready, bus_a.bus_err, bus_a.d_rdata} !== {3'b100, r}) begin
            n_fail++; $display("FAIL store_resp: got dr=%b ir=%b err=%b rd=%h want 1/0/0/%h",
                               bus_a.d_ready, bus_a.i_ready, bus_a.bus_err, bus_a.d_rdata, r);
        end
        bus_a.d_valid = 0;
        tick();
        n_cmp++;
        if (bus_a.d_ready !== 1'b0) begin
            n_fail++; $display("FAIL store_single_pulse: got %b want 0", bus_a.d_ready);
        end
    endtask

    task automatic test_ready_final_cycle();
        do_reset();
        bus_a.i_valid = 1; bus_a.i_addr = 32'h40;
        tick();
        for (int c = 1; c <= 4; c++) begin
            n_cmp++;
            if (bus_a.m_valid !== 1'b1) begin
                n_fail++; $display("FAIL final_mvalid c=%0d: got %b want 1", c, bus_a.m_valid);
            end
            bus_a.m_ready = (c == 4); bus_a.m_rdata = 32'hCAFE0004;
            tick();
        end
        bus_a.m_ready = 0;
        n_cmp++;
        if ({bus_a.i_ready, bus_a.bus_err, bus_a.i_rdata} !== {2'b10, 32'hCAFE0004}) begin
            n_fail++; $display("FAIL final_resp: got ir=%b err=%b rd=%h want 1/0/cafe0004",
                               bus_a.i_ready, bus_a.bus_err, bus_a.i_rdata);
        end
        bus_a.i_valid = 0;
        tick();
    endtask

    task automatic test_timeout();
        int cyc;
        do_reset();
        bus_a.d_valid = 1; bus_a.d_addr = 32'hA5A50040; bus_a.d_wstrb = 4'h0;
        tick();
        cyc = 0;
        while (bus_a.m_valid === 1'b1 && cyc < 20) begin
            cyc++;
            tick();
        end
        n_cmp++;
        if (cyc !== 4) begin
            n_fail++; $display("FAIL timeout_len: got %0d cycles want 4", cyc);
        end
        n_cmp++;
        if ({bus_a.d_ready, bus_a.i_ready, bus_a.bus_err, bus_a.d_rdata, bus_a.err_addr} !== {3'b101, 32'h0, 32'hA5A50040}) begin
            n_fail++; $display("FAIL timeout_resp: got dr=%b ir=%b err=%b rd=%h ea=%h want 1/0/1/0/a5a50040",
                               bus_a.d_ready, bus_a.i_ready, bus_a.bus_err, bus_a.d_rdata, bus_a.err_addr);
        end
        bus_a.d_valid = 0;
        bus_a.m_ready = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_cmp++;
            if ({bus_a.d_ready, bus_a.i_ready, bus_a.m_valid, bus_a.bus_err, bus_a.err_addr} !== {4'b0000, 32'hA5A50040}) begin
                n_fail++; $display("FAIL timeout_late k=%0d: got dr=%b ir=%b mv=%b err=%b ea=%h want 0/0/0/0/a5a50040",
                                   k, bus_a.d_ready, bus_a.i_ready, bus_a.m_valid, bus_a.bus_err, bus_a.err_addr);
            end
        end
        bus_a.m_ready = 0;
    endtask

    task automatic test_round_robin();
        bit want_d;
        do_reset();
        bus_a.i_valid = 1; bus_a.i_addr = 32'h10000000;
        bus_a.d_valid = 1; bus_a.d_addr = 32'h20000000;
        for (int t = 0; t < 4; t++) begin
            want_d = (t % 2 == 0);
            tick();
            n_cmp++;
            if (bus_a.m_addr !== (want_d ? bus_a.d_addr : bus_a.i_addr)) begin
                n_fail++; $display("FAIL rr_grant t=%0d: got addr %h want %s", t, bus_a.m_addr, want_d ? "d" : "i");
            end
            bus_a.m_ready = 1; bus_a.m_rdata = $urandom;
            tick();
            bus_a.m_ready = 0;
            n_cmp++;
            if ({bus_a.d_ready, bus_a.i_ready} !== {want_d, !want_d}) begin
                n_fail++; $display("FAIL rr_ready t=%0d: got d=%b i=%b want d=%b", t, bus_a.d_ready, bus_a.i_ready, want_d);
            end
            if (want_d) bus_a.d_addr = bus_a.d_addr + 32'h4;
            else        bus_a.i_addr = bus_a.i_addr + 32'h4;
            tick();
        end
        bus_a.i_valid = 0; bus_a.d_valid = 0;
        tick();
    endtask

    task automatic test_fixed_priority();
        do_reset();
        bus_b.i_valid = 1; bus_b.i_addr = 32'h30000000;
        bus_b.d_valid = 1; bus_b.d_addr = 32'h40000000;
        for (int t = 0; t < 4; t++) begin
            if (t == 3) bus_b.d_valid = 0;
            tick();
            n_cmp++;
            if (bus_b.m_addr !== (t < 3 ? 32'h40000000 : 32'h30000000)) begin
                n_fail++; $display("FAIL fixed_grant t=%0d: got addr %h want %s", t, bus_b.m_addr, t < 3 ? "d" : "i");
            end
            if (t == 1) begin
                for (int k = 0; k < 10; k++) tick();
                n_cmp++;
                if ({bus_b.m_valid, bus_b.bus_err, bus_b.d_ready} !== 3'b100) begin
                    n_fail++; $display("FAIL fixed_no_timeout: got %b want 100", {bus_b.m_valid, bus_b.bus_err, bus_b.d_ready});
                end
            end
            bus_b.m_ready = 1; bus_b.m_rdata = 32'h5A000000 + t;
            tick();
            bus_b.m_ready = 0;
            n_cmp++;
            if ({bus_b.d_ready, bus_b.i_ready} !== (t < 3 ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL fixed_ready t=%0d: got d=%b i=%b", t, bus_b.d_ready, bus_b.i_ready);
            end
            if (t == 3) bus_b.i_valid = 0;
            tick();
        end
    endtask

    task automatic test_reset_mid_issue();
        do_reset();
        bus_a.i_valid = 1; bus_a.i_addr = 32'h800;
        tick();
        n_cmp++;
        if (bus_a.m_valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_pre: got m_valid %b want 1", bus_a.m_valid);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb, bus_a.i_ready, bus_a.d_ready,
             bus_a.i_rdata, bus_a.d_rdata, bus_a.bus_err, bus_a.err_addr} !== '0) begin
            n_fail++; $display("FAIL midrst_async: got m_valid=%b m_addr=%h want all 0", bus_a.m_valid, bus_a.m_addr);
        end
        bus_a.i_valid = 0;
        tick();
        resetn = 1'b1;
        tick();
        n_cmp++;
        if ({bus_a.i_ready, bus_a.d_ready, bus_a.m_valid} !== 3'b000) begin
            n_fail++; $display("FAIL midrst_quiet: got %b want 000", {bus_a.i_ready, bus_a.d_ready, bus_a.m_valid});
        end
        bus_a.i_valid = 1; bus_a.i_addr = 32'h900;
        bus_a.d_valid = 1; bus_a.d_addr = 32'hA00;
        tick();
        n_cmp++;
        if (bus_a.m_addr !== 32'hA00) begin
            n_fail++; $display("FAIL midrst_tie: got addr %h want a00 (d)", bus_a.m_addr);
        end
        bus_a.m_ready = 1;
        tick();
        bus_a.m_ready = 0; bus_a.i_valid = 0; bus_a.d_valid = 0;
        tick();
    endtask

    task automatic test_random();
        bit          pi, pd, last_d, win_d, to;
        logic [31:0] ia, da, dw, ea, ew, r, exp_rd, err_a, got_rd;
        logic [3:0]  ds, es;
        int          w, ncyc;
        do_reset();
        pi = 0; pd = 0; last_d = 0; err_a = 0;
        ia = 0; da = 0; dw = 0; ds = 0;
        for (int n = 0; n < 80; n++) begin
            if (!pi && ($urandom % 3 != 0)) begin pi = 1; ia = $urandom & ~32'h3; end
            if (!pd && ($urandom % 3 != 0)) begin pd = 1; da = $urandom; dw = $urandom; ds = 4'($urandom); end
            bus_a.i_valid = pi; bus_a.i_addr = ia;
            bus_a.d_valid = pd; bus_a.d_addr = da; bus_a.d_wdata = dw; bus_a.d_wstrb = ds;
            if (!pi && !pd) begin
                tick();
                n_cmp++;
                if (bus_a.m_valid !== 1'b0) begin
                    n_fail++; $display("FAIL rand_idle n=%0d: got m_valid %b want 0", n, bus_a.m_valid);
                end
                continue;
            end
            win_d  = pd && (!pi || !last_d);
            ea     = win_d ? da : ia;
            ew     = win_d ? dw : 32'h0;
            es     = win_d ? ds : 4'h0;
            w      = $urandom_range(0, 5);
            to     = (w + 1 > 4);
            ncyc   = to ? 4 : w + 1;
            r      = $urandom;
            exp_rd = to ? 32'h0 : r;
            tick();
            for (int c = 1; c <= ncyc; c++) begin
                n_cmp++;
                if ({bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb} !== {1'b1, ea, ew, es}) begin
                    n_fail++; $display("FAIL rand_issue n=%0d c=%0d: got v=%b a=%h w=%h s=%h want 1/%h/%h/%h",
                                       n, c, bus_a.m_valid, bus_a.m_addr, bus_a.m_wdata, bus_a.m_wstrb, ea, ew, es);
                end
                bus_a.m_ready = (c == w + 1);
                bus_a.m_rdata = (c == w + 1) ? r : $urandom;
                tick();
            end
            bus_a.m_ready = 0;
            got_rd = win_d ? bus_a.d_rdata : bus_a.i_rdata;
            n_cmp++;
            if ({bus_a.m_valid, bus_a.i_ready, bus_a.d_ready, bus_a.bus_err} !== {1'b0, !win_d, win_d, to}) begin
                n_fail++; $display("FAIL rand_resp n=%0d: got mv=%b ir=%b dr=%b err=%b want 0/%b/%b/%b",
                                   n, bus_a.m_valid, bus_a.i_ready, bus_a.d_ready, bus_a.bus_err, !win_d, win_d, to);
            end
            n_cmp++;
            if (got_rd !== exp_rd) begin
                n_fail++; $display("FAIL rand_rdata n=%0d: got %h want %h", n, got_rd, exp_rd);
            end
            if (to) err_a = ea;
            n_cmp++;
            if (bus_a.err_addr !== err_a) begin
                n_fail++; $display("FAIL rand_err_addr n=%0d: got %h want %h", n, bus_a.err_addr, err_a);
            end
            if (win_d) pd = 0; else pi = 0;
            last_d = win_d;
            bus_a.i_valid = pi; bus_a.d_valid = pd;
            tick();
            n_cmp++;
            if ({bus_a.i_ready, bus_a.d_ready, bus_a.m_valid, bus_a.bus_err} !== 4'b0000) begin
                n_fail++; $display("FAIL rand_after n=%0d: got %b want 0000", n,
                                   {bus_a.i_ready, bus_a.d_ready, bus_a.m_valid, bus_a.bus_err});
            end
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        resetn = 1'b0;
        clear_inputs();
        tick();
        test_reset();
        test_single_read();
        test_store_wait();
        test_ready_final_cycle();
        test_timeout();
        test_round_robin();
        test_fixed_priority();
        test_reset_mid_issue();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end
endmodule
`default_nettype wire
